// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: packs ADC sample strobes into fixed-length frames and buffers them in a FIFO.
// Only whole frames are streamed out. Define ADC_FRAME_HDR_EN to put a {16'hADC5, seq} header word ahead of each frame.

module adc_frame_buffer #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic [31:0]   din,
  input  logic          din_valid,
  input  logic          enable,
  input  logic [15:0]   frame_len,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [AW:0]   level,
  output logic [15:0]   frame_cnt
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_TWO = (AW+1)'(2);

  logic [32:0] mem [DEPTH];
  logic [32:0] s1_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] idx_q, idx_d, flen_q, flen_d, frame_cnt_q, frame_cnt_d;
  logic        ovf_q, ovf_d;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d, tvalid_q, tvalid_d;

  logic [AW:0] rd_eff, used, wr_step;
  logic [15:0] cur_flen;
  logic        wr_fire, is_last, full, wr_en, s2_load, s1_take;

  // Occupancy is measured against the effective read pointer, so words parked in the
  // two output stages still hold their slots until they are transferred.
  always_comb begin
    wr_fire  = din_valid && enable;
    cur_flen = (idx_q == 16'd0) ? ((frame_len == 16'd0) ? 16'd1 : frame_len) : flen_q;
    is_last  = (idx_q == cur_flen - 16'd1);
    rd_eff   = rd_ptr_q - {{AW{1'b0}}, s1_valid_q} - {{AW{1'b0}}, tvalid_q};
    used     = wr_ptr_q - rd_eff;
`ifdef ADC_FRAME_HDR_EN
    full     = (idx_q == 16'd0) ? (used > DEPTH_W - PTR_TWO) : (used == DEPTH_W);
    wr_step  = (idx_q == 16'd0) ? PTR_TWO : PTR_ONE;
`else
    full     = (used == DEPTH_W);
    wr_step  = PTR_ONE;
`endif
  end

  // Frame assembly: commit on the last sample, roll back on overflow or disable.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    idx_d        = idx_q;
    flen_d       = flen_q;
    frame_cnt_d  = frame_cnt_q;
    ovf_d        = clr_ovf ? 1'b0 : ovf_q;
    wr_en        = 1'b0;
    if (wr_fire) begin
      if (full) begin
        wr_ptr_d = commit_ptr_q;
        idx_d    = 16'd0;
        ovf_d    = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + wr_step;
        flen_d   = cur_flen;
        if (is_last) begin
          commit_ptr_d = wr_ptr_q + wr_step;
          idx_d        = 16'd0;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
    end else if (!enable && idx_q != 16'd0) begin
      wr_ptr_d = commit_ptr_q;
      idx_d    = 16'd0;
    end
  end

  // Two-stage read: s1 is the registered memory output, s2 is the stream register.
  always_comb begin
    s2_load    = s1_valid_q && (!tvalid_q || m_tready);
    s1_take    = (rd_ptr_q != commit_ptr_q) && (!s1_valid_q || s2_load);
    rd_ptr_d   = s1_take ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    s1_valid_d = s1_take || (s1_valid_q && !s2_load);
    tvalid_d   = s2_load || (tvalid_q && !m_tready);
    tdata_d    = s2_load ? s1_q[31:0] : tdata_q;
    tlast_d    = s2_load ? s1_q[32] : tlast_q;
  end

`ifdef ADC_FRAME_HDR_EN
  logic [AW-1:0] wr_addr1;
  assign wr_addr1 = wr_ptr_q[AW-1:0] + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef ADC_FRAME_HDR_EN
      if (idx_q == 16'd0) begin
        mem[wr_ptr_q[AW-1:0]] <= {1'b0, 16'hADC5, frame_cnt_q};
        mem[wr_addr1]         <= {is_last, din};
      end else begin
        mem[wr_ptr_q[AW-1:0]] <= {is_last, din};
      end
`else
      mem[wr_ptr_q[AW-1:0]] <= {is_last, din};
`endif
    end
    if (s1_take) s1_q <= mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      flen_q       <= 16'd1;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      flen_q       <= flen_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_q        <= ovf_d;
      s1_valid_q   <= s1_valid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign overflow  = ovf_q;
  assign frame_cnt = frame_cnt_q;
  assign level     = commit_ptr_q - rd_eff;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: randomized and directed stimulus against a queue-based frame model.
// Runs with or without ADC_FRAME_HDR_EN; the header scenario is only built when it is defined.

module tb_adc_frame_buffer;

  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
`ifdef ADC_FRAME_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [31:0]   din = '0;
  logic          din_valid = 1'b0;
  logic          enable = 1'b1;
  logic [15:0]   frame_len = 16'd4;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          overflow;
  logic          clr_ovf = 1'b0;
  logic [AW:0]   level;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  adc_frame_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .arstn(arstn), .din(din), .din_valid(din_valid), .enable(enable),
    .frame_len(frame_len), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .overflow(overflow), .clr_ovf(clr_ovf), .level(level),
    .frame_cnt(frame_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model state: committed words not yet transferred, and the frame being assembled.
  logic [32:0] mq_commit[$];
  logic [32:0] mq_part[$];
  logic [32:0] rx[$];
  logic [31:0] sent[$];
  int          m_idx, m_flen, stall;
  logic [15:0] m_fcnt;
  logic        m_ovf;
  logic        prev_tvalid, prev_tlast;
  logic [31:0] prev_tdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq_commit.delete();
    mq_part.delete();
    m_idx = 0;
    m_flen = 1;
    m_fcnt = '0;
    m_ovf = 1'b0;
    stall = 0;
  endtask

  // Monitor runs 1 time unit after each edge; stimulus changes 2 units after, so the
  // inputs seen here are the ones the DUT just sampled.
  initial begin : monitor
    int occ;
    bit xfer, drop;
    logic [32:0] w;
    modelReset();
    forever begin
      @(posedge clk);
      #1;
      if (!arstn) begin
        modelReset();
      end else begin
        occ  = mq_commit.size() + mq_part.size();
        xfer = prev_tvalid && m_tready;
        if (xfer) begin
          rx.push_back({prev_tlast, prev_tdata});
          if (mq_commit.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL xfer_when_empty: got %0h, expected no transfer", prev_tdata);
          end else begin
            w = mq_commit.pop_front();
            checkOutput("xfer_word", {31'd0, prev_tlast, prev_tdata}, {31'd0, w});
          end
        end
        drop = 1'b0;
        if (din_valid && enable) begin
          if (m_idx == 0) m_flen = (frame_len == 16'd0) ? 1 : int'(frame_len);
          if (occ + ((HDR && m_idx == 0) ? 2 : 1) > DEPTH) begin
            drop = 1'b1;
            mq_part.delete();
            m_idx = 0;
          end else begin
            if (HDR && m_idx == 0) mq_part.push_back({1'b0, 16'hADC5, m_fcnt});
            mq_part.push_back({(m_idx == m_flen - 1), din});
            if (m_idx == m_flen - 1) begin
              foreach (mq_part[i]) mq_commit.push_back(mq_part[i]);
              mq_part.delete();
              m_idx = 0;
              m_fcnt = m_fcnt + 16'd1;
            end else begin
              m_idx++;
            end
          end
        end else if (!enable) begin
          mq_part.delete();
          m_idx = 0;
        end
        m_ovf = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);

        checkOutput("level", 64'(level), 64'(mq_commit.size()));
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        if (prev_tvalid && !m_tready) begin
          checkOutput("hold_tvalid", 64'(m_tvalid), 64'd1);
          checkOutput("hold_tdata", 64'(m_tdata), 64'(prev_tdata));
          checkOutput("hold_tlast", 64'(m_tlast), 64'(prev_tlast));
        end
        if (m_tvalid) begin
          if (mq_commit.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL tvalid_no_data: got tvalid=1, expected 0 with no committed words");
          end else begin
            checkOutput("head_word", {31'd0, m_tlast, m_tdata}, {31'd0, mq_commit[0]});
          end
        end
        if (!m_tvalid && mq_commit.size() > 0) stall++;
        else stall = 0;
        if (mq_commit.size() > 0) checkOutput("tvalid_latency", 64'(stall > 2), 64'd0);
      end
      prev_tvalid = m_tvalid;
      prev_tdata  = m_tdata;
      prev_tlast  = m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic doReset();
    arstn = 1'b0;
    din_valid = 1'b0;
    clr_ovf = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    arstn = 1'b1;
    rx.delete();
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_tdata", 64'(m_tdata), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
  endtask

  task automatic waitRx(input int n, input int budget);
    for (int c = 0; c < budget && rx.size() < n; c++) tick();
    checkOutput("drain_count", 64'(rx.size()), 64'(n));
    tick();
  endtask

  initial begin : stimulus
    int n;
    doReset();

`ifndef ADC_FRAME_HDR_EN
    // Two 4-sample frames streamed straight through.
    frame_len = 16'd4;
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(32'(i));
    checkOutput("rise_e0", 64'(m_tvalid), 64'd0);
    tick();
    checkOutput("rise_e1", 64'(m_tvalid), 64'd0);
    tick();
    checkOutput("rise_e2", 64'(m_tvalid), 64'd1);
    for (int i = 5; i <= 8; i++) applyStimulus(32'(i));
    waitRx(8, 40);
    for (int i = 0; i < 8 && i < rx.size(); i++) begin
      checkOutput("t1_data", 64'(rx[i][31:0]), 64'(i + 1));
      checkOutput("t1_last", 64'(rx[i][32]), 64'(i == 3 || i == 7));
    end
    checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'd2);

    // Nothing is visible until the frame completes.
    doReset();
    m_tready = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(32'(i));
    tick();
    tick();
    tick();
    checkOutput("t2_tvalid_partial", 64'(m_tvalid), 64'd0);
    checkOutput("t2_level_partial", 64'(level), 64'd0);
    applyStimulus(32'd4);
    checkOutput("t2_level_commit", 64'(level), 64'd4);
    tick();
    tick();
    tick();
    checkOutput("t2_head_held", 64'(m_tdata), 64'd1);

    // Overflow on the 17th strobe with a coincident clear; partial frame 3 is discarded.
    doReset();
    frame_len = 16'd6;
    m_tready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      clr_ovf = (i == 17);
      applyStimulus(32'(i));
    end
    clr_ovf = 1'b0;
    checkOutput("t3_overflow", 64'(overflow), 64'd1);
    checkOutput("t3_level", 64'(level), 64'd12);
    checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'd2);
    m_tready = 1'b1;
    waitRx(12, 60);
    for (int i = 0; i < 12 && i < rx.size(); i++) begin
      checkOutput("t3_data", 64'(rx[i][31:0]), 64'(i + 1));
      checkOutput("t3_last", 64'(rx[i][32]), 64'(i == 5 || i == 11));
    end
    for (int i = 21; i <= 23; i++) applyStimulus(32'(i));
    waitRx(18, 40);
    for (int i = 12; i < 18 && i < rx.size(); i++) begin
      checkOutput("t3_restart_data", 64'(rx[i][31:0]), 64'(i + 6));
      checkOutput("t3_restart_last", 64'(rx[i][32]), 64'(i == 17));
    end
    checkOutput("t3_frame_cnt_after", 64'(frame_cnt), 64'd3);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checkOutput("t3_overflow_cleared", 64'(overflow), 64'd0);

    // Disabling mid-frame throws the partial frame away.
    doReset();
    frame_len = 16'd8;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(32'h100 + 32'(i));
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(32'h200 + 32'(i));
    waitRx(8, 40);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      checkOutput("t4_data", 64'(rx[i][31:0]), 64'(32'h200 + 32'(i)));
    checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'd1);
`endif

    // Random backpressure; strobes are held off whenever the buffer is full.
    doReset();
    frame_len = 16'd3;
    sent.delete();
    n = 0;
    for (int cyc = 0; cyc < 20000 && n < 300; cyc++) begin
      m_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && (mq_commit.size() + mq_part.size()) < DEPTH - 1) begin
        din = $urandom;
        din_valid = 1'b1;
        sent.push_back(din);
        n++;
      end else begin
        din_valid = 1'b0;
      end
      tick();
    end
    din_valid = 1'b0;
    m_tready = 1'b1;
`ifndef ADC_FRAME_HDR_EN
    waitRx(300, 2000);
    for (int i = 0; i < 300 && i < rx.size(); i++) begin
      checkOutput("t5_data", 64'(rx[i][31:0]), 64'(sent[i]));
      checkOutput("t5_last", 64'(rx[i][32]), 64'(i % 3 == 2));
    end
    checkOutput("t5_no_overflow", 64'(overflow), 64'd0);
`else
    waitRx(400, 2000);

    // Header word ahead of each frame.
    doReset();
    frame_len = 16'd2;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + 32'(i));
    waitRx(6, 40);
    if (rx.size() == 6) begin
      checkOutput("hdr_w0", 64'(rx[0]), 64'({1'b0, 32'hADC50000}));
      checkOutput("hdr_w1", 64'(rx[1]), 64'({1'b0, 32'hA0}));
      checkOutput("hdr_w2", 64'(rx[2]), 64'({1'b1, 32'hA1}));
      checkOutput("hdr_w3", 64'(rx[3]), 64'({1'b0, 32'hADC50001}));
      checkOutput("hdr_w4", 64'(rx[4]), 64'({1'b0, 32'hA2}));
      checkOutput("hdr_w5", 64'(rx[5]), 64'({1'b1, 32'hA3}));
    end
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

endmodule
